// File: rtl/utopia1_atm_rx.sv
// UTOPIA level-1 ATM cell receiver.
// Reassembles 53-byte cells from a soc/data/en byte stream into NNI header
// fields plus a 48-byte payload, checks the HEC (CRC-8 + coset), and offers
// the cell downstream with an rxreq/rxack handshake. A single-cell holding
// buffer back-pressures the transmitter through clav.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   soc, data, en   start of cell, cell byte, byte-valid strobe (inputs)
//   clav            cell space available (registered)
//   rxreq, rxack    cell-held request / consumer acknowledge
//   nni_VPI/VCI/CLP/PT/HEC, nni_Payload   received cell fields
//   hec_err         HEC mismatch for the held cell
//   cell_drop       pulse: partial cell discarded by an early soc
//   overrun         pulse: soc&en arrived while a cell is held
module utopia1_atm_rx #(
  parameter bit         CHECK_HEC = 1'b1,
  parameter logic [7:0] HEC_COSET = 8'h55
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         soc,
  input  logic [7:0]   data,
  input  logic         en,
  output logic         clav,
  output logic         rxreq,
  input  logic         rxack,
  output logic [11:0]  nni_VPI,
  output logic [15:0]  nni_VCI,
  output logic         nni_CLP,
  output logic [2:0]   nni_PT,
  output logic [7:0]   nni_HEC,
  output logic [383:0] nni_Payload,
  output logic         hec_err,
  output logic         cell_drop,
  output logic         overrun
);

  localparam int unsigned IDX_W    = 6;
  localparam int unsigned LAST_IDX = 52;
  localparam int unsigned HEC_IDX  = 4;
  localparam int unsigned PAY_IDX  = 5;

  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       crc;
  logic             start_c, take_c, drop_c, over_c;
  logic [IDX_W-1:0] pay_sel_c;

  // CRC-8 (x^8+x^2+x+1) advanced by one byte, MSB first
  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and byte-acceptance decode
  always_comb begin
    next_state = state;
    start_c    = 1'b0;
    take_c     = 1'b0;
    drop_c     = 1'b0;
    over_c     = 1'b0;
    case (state)
      IDLE: begin
        if (en && soc) begin
          start_c    = 1'b1;
          next_state = RECV;
        end
      end
      RECV: begin
        if (en) begin
          if (soc) begin
            // early start of cell restarts reception with this byte as byte 0
            start_c = 1'b1;
            drop_c  = 1'b1;
          end else begin
            take_c = 1'b1;
            if (idx == IDX_W'(LAST_IDX)) next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (en && soc) over_c = 1'b1;
        if (rxack)     next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign pay_sel_c = idx - IDX_W'(PAY_IDX);

  // Handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      clav      <= 1'b0;
      rxreq     <= 1'b0;
      cell_drop <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      clav      <= (next_state != HOLD);
      rxreq     <= (next_state == HOLD);
      cell_drop <= drop_c;
      overrun   <= over_c;
    end
  end

  // Byte counter, running CRC and field capture
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      crc         <= '0;
      nni_VPI     <= '0;
      nni_VCI     <= '0;
      nni_CLP     <= 1'b0;
      nni_PT      <= '0;
      nni_HEC     <= '0;
      nni_Payload <= '0;
      hec_err     <= 1'b0;
    end else if (start_c) begin
      idx           <= IDX_W'(1);
      nni_VPI[11:4] <= data;
      crc           <= crc8_byte(8'h00, data);
    end else if (take_c) begin
      idx <= (idx == IDX_W'(LAST_IDX)) ? '0 : idx + IDX_W'(1);
      case (idx)
        IDX_W'(1): begin
          nni_VPI[3:0]   <= data[7:4];
          nni_VCI[15:12] <= data[3:0];
          crc            <= crc8_byte(crc, data);
        end
        IDX_W'(2): begin
          nni_VCI[11:4] <= data;
          crc           <= crc8_byte(crc, data);
        end
        IDX_W'(3): begin
          nni_VCI[3:0] <= data[7:4];
          nni_CLP      <= data[3];
          nni_PT       <= data[2:0];
          crc          <= crc8_byte(crc, data);
        end
        IDX_W'(HEC_IDX): begin
          nni_HEC <= data;
          hec_err <= CHECK_HEC && ((crc ^ HEC_COSET) != data);
        end
        default: begin
          if (idx >= IDX_W'(PAY_IDX)) nni_Payload[{pay_sel_c, 3'b000} +: 8] <= data;
        end
      endcase
    end
  end

endmodule

// File: doc/utopia1_atm_rx.md
# utopia1_atm_rx

UTOPIA level-1 cell receiver sitting directly downstream of `utopia1_atm_tx`. It consumes the transmitter's `soc`/`data`/`en` byte stream and drives `clav` back to it. It reassembles each 53-byte cell into NNI header fields plus a 48-byte payload, checks the HEC, and hands the cell to the next stage with a `rxreq`/`rxack` handshake. A single-cell holding buffer provides back-pressure through `clav`.

## Interface
- `CHECK_HEC`, default 1: when 1, the HEC is computed and compared; when 0, `hec_err` is tied to 0.
- `HEC_COSET`, default 8'h55: coset value XORed onto the CRC-8 remainder.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `soc` in 1: start of cell; qualified by `en`.
- `data` in 8: cell byte; valid when `en`=1.
- `en` in 1: byte-valid strobe from the transmitter.
- `clav` out 1: cell space available; registered.
- `rxreq` out 1: a complete cell is held on the `nni_*` outputs.
- `rxack` in 1: the consumer has taken the cell.
- `nni_VPI` out 12, `nni_VCI` out 16, `nni_CLP` out 1, `nni_PT` out 3, `nni_HEC` out 8: received header fields.
- `nni_Payload` out 384: payload. Byte k sits at [8k+7:8k], and byte 0 is the first payload byte on the wire.
- `hec_err` out 1: HEC mismatch for the held cell; valid while `rxreq`=1.
- `cell_drop` out 1: one-cycle pulse when a partial cell is discarded.
- `overrun` out 1: one-cycle pulse when `soc`&`en` arrives in HOLD.

## Operation
- States:
  - IDLE: waiting for a start of cell.
  - RECV: receiving; byte counter `idx` runs 0..52.
  - HOLD: cell complete, waiting for the consumer.
- A byte is "accepted" on a clock edge where `en`=1, in IDLE or RECV.
- IDLE:
  - `soc`&`en` → capture `data` as byte 0, set `idx`=1, go to RECV.
  - `en`=1 with `soc`=0 is ignored. This covers the zero filler bytes the transmitter emits before its start of cell.
- RECV, byte mapping:
  - byte0 = `VPI[11:4]`
  - byte1 = {`VPI[3:0]`, `VCI[15:12]`}
  - byte2 = `VCI[11:4]`
  - byte3 = {`VCI[3:0]`, `CLP`, `PT[2:0]`}, i.e. `CLP`=bit3, `PT`=bits2:0
  - byte4 = `HEC`
  - bytes 5..52 = payload bytes 0..47
- RECV, pacing: `en`=0 cycles are wait states; `idx` holds.
- RECV, completion: when byte 52 is accepted, go to HOLD.
- RECV, early start of cell: `soc`&`en` with `idx`≥1 → pulse `cell_drop`, discard the partial cell, treat this byte as byte 0, set `idx`=1.
- HOLD:
  - `rxreq`=1; all `nni_*` outputs and `hec_err` are frozen.
  - `rxack` sampled high → IDLE on the next edge.
  - Inputs are ignored, except that `soc`&`en` pulses `overrun`. Such a cell is lost, not buffered.
- HEC check:
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00.
  - Computed over bytes 0..3, MSB first; the remainder is then XORed with `HEC_COSET`.
  - The check may be incremental (one byte per accepted header byte) or performed at byte 4.
  - `hec_err` = (computed ≠ byte4), registered when byte 4 is accepted.
  - A cell with `hec_err`=1 is still delivered.
- `clav` <= (next_state ≠ HOLD).

## Timing
- Reset values:
  - `clav`=0, `rxreq`=0, `hec_err`=0, `cell_drop`=0, `overrun`=0.
  - All `nni_*` = 0; state IDLE; `idx`=0.
- `clav` rises on the first edge after `rst` deasserts.
- Delivery latency: byte 52 accepted at edge t → `rxreq`=1 and `clav`=0 from edge t onward, with fields stable.
- Release: `rxack`=1 at edge u while `rxreq`=1 → `rxreq`=0 and `clav`=1 from edge u. A start of cell accepted at edge u+1 is received normally.
- `rxack` while `rxreq`=0 is ignored.
- `rst` mid-cell or in HOLD: all reset values apply on the next edge. The partial or held cell is lost, and no `cell_drop` pulse is generated.
- Because `clav` drops only at a cell boundary, the transmitter's one-cycle `clav`→`en` lag never splits a cell. A mid-cell byte arriving while `clav`=0 cannot occur.

## Test plan
- Single cell:
  - Stimulus: transmitter loopback with VPI=12'hABC, VCI=16'h1234, CLP=1, PT=3'b101, HEC=8'h5A, payload byte k = k.
  - Expected: `rxreq` on the edge of byte 52; all fields match; `nni_Payload[7:0]`=8'h00 and `[383:376]`=8'h2F.
- HEC check:
  - All-zero header with HEC 8'h55 → `hec_err`=0.
  - Same header with HEC 8'h54 → `hec_err`=1, and the cell is still delivered.
- Gapped stream:
  - Stimulus: `en` low for 3 cycles after bytes 2, 20 and 51.
  - Expected: identical captured cell; `rxreq` delayed exactly 9 cycles relative to the ungapped case.
- Back-pressure:
  - Stimulus: withhold `rxack` for 20 cycles, then pulse it for one cycle.
  - Expected: `clav`=0 and fields frozen throughout the hold; `clav`=1 on the ack edge; a second cell is received correctly.
- Early start of cell:
  - Stimulus: `soc` at byte 30, followed by a full cell.
  - Expected: one `cell_drop` pulse; the second cell is delivered intact.
- Overrun and reset:
  - `soc`&`en` during HOLD → `overrun` pulse; the held cell is unchanged.
  - `rst` at byte 25 → all outputs take reset values on the next edge; `clav`=1 one edge after `rst` deasserts.
